// File: rtl/class_hvec_sim_reader.sv
// Hamming-similarity classifier. Buffers one query hypervector (N_FRAMES
// frames), then reads every class hypervector frame by frame from the store.
// It scores each class as popcount(XNOR) and returns the best class.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid is high and
// ready is low. query_ready is high only in LOAD. result_valid is high only
// in DONE, and the result stays stable until result_ready is seen.
module class_hvec_sim_reader #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int N_CLASSES          = 8,
  parameter int N_FRAMES           = 3,
  parameter int CLASS_ID_W         = 3,
  parameter int FRAME_IDX_W        = 2,
  parameter int SCORE_W            = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          query_valid,
  output logic                          query_ready,
  input  logic [DI_PARALLEL_W_BITS-1:0] query_frame,
  output logic [CLASS_ID_W-1:0]         frame_id,
  output logic [FRAME_IDX_W-1:0]        frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
  output logic                          busy,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [CLASS_ID_W-1:0]         pred_class,
  output logic [SCORE_W-1:0]            best_score,
  output logic [1:0]                    dbg_state
);

  localparam int POP_W = $clog2(DI_PARALLEL_W_BITS + 1);
  localparam logic [FRAME_IDX_W-1:0] LAST_FRM = FRAME_IDX_W'(N_FRAMES - 1);
  localparam logic [CLASS_ID_W-1:0]  LAST_CLS = CLASS_ID_W'(N_CLASSES - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DI_PARALLEL_W_BITS-1:0] qbuf [N_FRAMES];
  logic [FRAME_IDX_W-1:0]        qcnt;
  logic [CLASS_ID_W-1:0]         cls;
  logic [FRAME_IDX_W-1:0]        frm;
  logic [SCORE_W-1:0]            acc;
  logic [SCORE_W-1:0]            best_q;
  logic [CLASS_ID_W-1:0]         pred_q;
  logic [DI_PARALLEL_W_BITS-1:0] agree;
  logic [POP_W-1:0]              pop;
  logic [SCORE_W-1:0]            total;
  logic                          q_fire;
  logic                          last_frm;

  assign q_fire   = (state == LOAD) && query_valid;
  assign last_frm = (frm == LAST_FRM);
  assign total    = acc + SCORE_W'(pop);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next state and state-decoded outputs. Store addresses are forced to 0 outside SCAN.
  always_comb begin
    state_nxt    = state;
    query_ready  = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    frame_id     = '0;
    frame_index  = '0;
    case (state)
      LOAD: begin
        query_ready = 1'b1;
        if (query_valid && (qcnt == LAST_FRM)) state_nxt = SCAN;
      end
      SCAN: begin
        busy        = 1'b1;
        frame_id    = cls;
        frame_index = frm;
        if ((cls == LAST_CLS) && last_frm) state_nxt = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Count the bits of the current query frame that agree with the store frame.
  always_comb begin
    agree = ~(qbuf[frm] ^ class_vec_in);
    pop   = '0;
    for (int i = 0; i < DI_PARALLEL_W_BITS; i++) pop = pop + POP_W'(agree[i]);
  end

  // Query buffer. It is left unreset because frames are always written before they are read.
  always_ff @(posedge clk) begin
    if (!rst && q_fire) qbuf[qcnt] <= query_frame;
  end

  // Counters, accumulator and best-so-far. Strict > keeps the lowest class id on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt   <= '0;
      cls    <= '0;
      frm    <= '0;
      acc    <= '0;
      best_q <= '0;
      pred_q <= '0;
    end else begin
      if (q_fire) qcnt <= (qcnt == LAST_FRM) ? '0 : qcnt + 1'b1;
      if (state == SCAN) begin
        if (last_frm) begin
          if ((total > best_q) || (cls == '0)) begin
            best_q <= total;
            pred_q <= cls;
          end
          acc <= '0;
          frm <= '0;
          cls <= (cls == LAST_CLS) ? '0 : cls + 1'b1;
        end else begin
          acc <= total;
          frm <= frm + 1'b1;
        end
      end
    end
  end

  assign pred_class = pred_q;
  assign best_score = best_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_class_hvec_sim_reader.sv
// Directed bench for class_hvec_sim_reader with a combinational store stub.
// Store data for class c, frame f is eight copies of the byte c*16+f.
module tb_class_hvec_sim_reader;

  localparam int W   = 64;
  localparam int CW  = 3;
  localparam int FW  = 2;
  localparam int SW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          query_valid;
  logic          query_ready;
  logic [W-1:0]  query_frame;
  logic [CW-1:0] frame_id;
  logic [FW-1:0] frame_index;
  logic [W-1:0]  class_vec_in;
  logic          busy;
  logic          result_valid;
  logic          result_ready;
  logic [CW-1:0] pred_class;
  logic [SW-1:0] best_score;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_acc = 0;
  bit stub_same = 1'b0;

  class_hvec_sim_reader dut (
    .clk          (clk),
    .rst          (rst),
    .query_valid  (query_valid),
    .query_ready  (query_ready),
    .query_frame  (query_frame),
    .frame_id     (frame_id),
    .frame_index  (frame_index),
    .class_vec_in (class_vec_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .pred_class   (pred_class),
    .best_score   (best_score),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Store stub: normal pattern, or every class equal to the class-0 pattern.
  always_comb begin
    if (stub_same) class_vec_in = {8{{1'b0, 3'd0, 2'b00, frame_index}}};
    else           class_vec_in = {8{{1'b0, frame_id, 2'b00, frame_index}}};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_frame(input logic [2:0] c, input int f, input bit inv);
    logic [1:0] fi;
    logic [W-1:0] v;
    fi = 2'(f);
    v  = {8{{1'b0, c, 2'b00, fi}}};
    return inv ? ~v : v;
  endfunction

  // Sends one full query with 'gap' idle cycles before each frame. Call at a negedge.
  task automatic send_query(input logic [2:0] c, input bit inv, input int gap);
    for (int f = 0; f < 3; f++) begin
      repeat (gap) begin
        query_valid = 1'b0;
        query_frame = '1;
        @(negedge clk);
      end
      query_valid = 1'b1;
      query_frame = mk_frame(c, f, inv);
      t_acc = cyc;
      @(negedge clk);
    end
    query_valid = 1'b0;
  endtask

  // Follows the scan, checks latency/addresses/result, then completes the result handshake.
  task automatic wait_result(input logic [2:0] exp_pred, input logic [7:0] exp_score,
                             input int hold, input bit keep_ready);
    int nbusy;
    bit seen;
    nbusy = 0;
    seen  = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      if (busy) begin
        check("scan_addr", {frame_id, frame_index}, {3'(nbusy / 3), 2'(nbusy % 3)});
        check("scan_qready", query_ready, 0);
        nbusy++;
      end
      @(negedge clk);
    end
    check("result_seen", seen, 1);
    check("latency", cyc - t_acc, 25);
    check("busy_cycles", nbusy, 24);
    check("pred_class", pred_class, exp_pred);
    check("best_score", best_score, exp_score);
    check("done_addr", {frame_id, frame_index}, 0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_pred", pred_class, exp_pred);
      check("hold_score", best_score, exp_score);
      check("hold_qready", query_ready, 0);
      check("hold_busy", busy, 0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    check("reload_qready", query_ready, 1);
    check("reload_valid", result_valid, 0);
    if (!keep_ready) result_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    query_valid  = 1'b0;
    query_frame  = '0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_qready", query_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_addr", {frame_id, frame_index}, 0);
    check("rst_pred", pred_class, 0);
    check("rst_score", best_score, 0);

    // Exact match with class 5: full score.
    send_query(3'd5, 1'b0, 0);
    wait_result(3'd5, 8'd192, 0, 1'b0);

    // Inverted class 3: agreement is 24*popcount(c^3), so class 4 wins with 72.
    send_query(3'd3, 1'b1, 0);
    wait_result(3'd4, 8'd72, 0, 1'b0);

    // All classes identical: tie resolves to class 0; 0x50 xor gives 6 agreeing bits/byte.
    stub_same = 1'b1;
    send_query(3'd5, 1'b0, 0);
    wait_result(3'd0, 8'd144, 0, 1'b0);
    stub_same = 1'b0;

    // Gapped query_valid and a consumer that stalls for 10 cycles.
    send_query(3'd7, 1'b0, 2);
    wait_result(3'd7, 8'd192, 10, 1'b0);

    // Reset in the middle of LOAD drops the partial query.
    query_valid = 1'b1;
    query_frame = mk_frame(3'd6, 0, 1'b0);
    @(negedge clk);
    query_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstload_qready", query_ready, 1);

    // Reset at SCAN cycle 7 aborts the scan.
    send_query(3'd6, 1'b0, 0);
    repeat (7) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstscan_qready", query_ready, 1);
    check("rstscan_busy", busy, 0);
    check("rstscan_valid", result_valid, 0);
    check("rstscan_id", frame_id, 0);
    check("rstscan_score", best_score, 0);

    // A fresh query scores correctly after the abort.
    send_query(3'd2, 1'b0, 0);
    wait_result(3'd2, 8'd192, 0, 1'b0);

    // Back-to-back queries with result_ready held high.
    result_ready = 1'b1;
    send_query(3'd1, 1'b0, 0);
    wait_result(3'd1, 8'd192, 0, 1'b1);
    send_query(3'd6, 1'b0, 0);
    wait_result(3'd6, 8'd192, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
